// File: rtl/snake_body_engine.sv
// Snake state engine: segment storage, stepping, growth, wall/self collision, win
// detection, plus a one-cycle "is this cell head/body?" query for the pixel path.
module snake_body_engine #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int CW       = 6,
    parameter int LW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [1:0]    dir_in,
    input  logic          grow,
    input  logic [CW-1:0] qx,
    input  logic [CW-1:0] qy,
    output logic [CW-1:0] head_x,
    output logic [CW-1:0] head_y,
    output logic [LW-1:0] len,
    output logic          hit_head,
    output logic          hit_body,
    output logic [1:0]    state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10,
        ST_WON  = 2'b11
    } state_t;

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_U = 2'b01;
    localparam logic [1:0] DIR_L = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    state_t        state_q;
    logic [1:0]    dir_q;
    logic [1:0]    dir_d;
    logic [LW-1:0] len_q;
    logic          grow_pend_q;
    logic          hit_head_q;
    logic          hit_body_q;
    logic [CW-1:0] seg_x_q [MAX_LEN];
    logic [CW-1:0] seg_y_q [MAX_LEN];

    logic [CW-1:0]      next_x;
    logic [CW-1:0]      next_y;
    logic               wall_hit;
    logic               grow_eff;
    logic [LW-1:0]      chk_lim;
    logic [MAX_LEN-1:0] self_vec;
    logic [MAX_LEN-1:0] body_vec;
    logic               collide;

    // Reverse requests flip bit 1 of the direction code; those keep the old heading.
    always_comb begin
        dir_d    = (dir_in == (dir_q ^ 2'b10)) ? dir_q : dir_in;
        next_x   = seg_x_q[0];
        next_y   = seg_y_q[0];
        wall_hit = 1'b0;
        case (dir_d)
            DIR_R: begin
                wall_hit = (seg_x_q[0] == CW'(GRID_W - 1));
                next_x   = seg_x_q[0] + CW'(1);
            end
            DIR_U: begin
                wall_hit = (seg_y_q[0] == '0);
                next_y   = seg_y_q[0] - CW'(1);
            end
            DIR_L: begin
                wall_hit = (seg_x_q[0] == '0);
                next_x   = seg_x_q[0] - CW'(1);
            end
            default: begin
                wall_hit = (seg_y_q[0] == CW'(GRID_H - 1));
                next_y   = seg_y_q[0] + CW'(1);
            end
        endcase
    end

    assign grow_eff = (grow_pend_q | grow) && (len_q < LW'(MAX_LEN));
    // Without growth the tail cell is vacated this step, so it is excluded.
    assign chk_lim  = grow_eff ? len_q : len_q - LW'(1);

    assign self_vec[0] = 1'b0;
    assign body_vec[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_cmp
            assign self_vec[gi] = (LW'(gi) < chk_lim) &&
                                  (seg_x_q[gi] == next_x) && (seg_y_q[gi] == next_y);
            assign body_vec[gi] = (LW'(gi) < len_q) &&
                                  (seg_x_q[gi] == qx) && (seg_y_q[gi] == qy);
        end
    endgenerate

    assign collide = wall_hit | (|self_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_R;
            len_q       <= LW'(INIT_LEN);
            grow_pend_q <= 1'b0;
            hit_head_q  <= 1'b0;
            hit_body_q  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? CW'(GRID_W / 2 - i) : '0;
                seg_y_q[i] <= (i < INIT_LEN) ? CW'(GRID_H / 2) : '0;
            end
        end else begin
            hit_head_q <= (seg_x_q[0] == qx) && (seg_y_q[0] == qy);
            hit_body_q <= |body_vec;
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (step) begin
                        if (collide) begin
                            state_q <= ST_DEAD;
                        end else begin
                            dir_q      <= dir_d;
                            seg_x_q[0] <= next_x;
                            seg_y_q[0] <= next_y;
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg_x_q[i] <= seg_x_q[i-1];
                                seg_y_q[i] <= seg_y_q[i-1];
                            end
                            if (grow_eff) begin
                                len_q       <= len_q + LW'(1);
                                grow_pend_q <= 1'b0;
                                if (len_q + LW'(1) == LW'(MAX_LEN)) state_q <= ST_WON;
                            end
                        end
                    end else if (grow && (len_q < LW'(MAX_LEN))) begin
                        grow_pend_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_x   = seg_x_q[0];
    assign head_y   = seg_y_q[0];
    assign len      = len_q;
    assign state    = state_q;
    assign hit_head = hit_head_q;
    assign hit_body = hit_body_q;
endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake state engine for the VGA Snake game: holds head and body segment coordinates in grid-cell units, advances the snake one cell per `step` pulse, handles growth, wall and self collision, and win detection. It also answers a pipelined per-pixel "is this cell head/body?" query for the colour mux. It sits between the tick divider / input decoder and the pixel renderer, replacing fixed-length, fixed-size body storage.

## Interface

- `MAX_LEN`, 32: maximum number of segments, head included; must be ≥ `INIT_LEN`.
- `INIT_LEN`, 3: length after reset; must be ≥ 2 and ≤ `GRID_W/2`.
- `GRID_W`, 32: playfield width in cells.
- `GRID_H`, 24: playfield height in cells.
- `CW`, 6: cell-coordinate width; must satisfy 2^`CW` > max(`GRID_W`, `GRID_H`).
- `LW`, 6: length-counter width; must satisfy 2^`LW` > `MAX_LEN`.

Ports:

- `clk` in 1: system clock; the pixel-clock domain is used.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; IDLE→RUN.
- `step` in 1: one-cycle pulse; advances the snake one cell.
- `dir_in` in 2: requested direction, sampled on `step`. 00 = right, 01 = up, 10 = left, 11 = down.
- `grow` in 1: one-cycle pulse, apple eaten; sets a pending-growth flag.
- `qx`, `qy` in `CW`: cell being rendered.
- `head_x`, `head_y` out `CW`: current head cell.
- `len` out `LW`: current length.
- `hit_head` out 1: registered; query cell equals the head.
- `hit_body` out 1: registered; query cell equals a valid non-head segment.
- `state` out 2: 00 = IDLE, 01 = RUN, 10 = DEAD, 11 = WON.

## Operation

- Storage: `seg_x`/`seg_y[0..MAX_LEN-1]`. Index 0 is the head. Index i is valid iff i < `len`. Invalid entries are ignored by every comparison.
- Reset values (immediate, asynchronous):
  - state IDLE, `len` = `INIT_LEN`, direction = right, grow_pend = 0.
  - seg[i] = (`GRID_W`/2 − i, `GRID_H`/2) for i < `INIT_LEN`; all other entries = (0,0).
  - `hit_head` = `hit_body` = 0.
- IDLE: `step` and `grow` are ignored. `start` → RUN.
- RUN, on `step`:
  1. New direction = `dir_in`, unless it is the exact reverse of the current direction. In that case keep the current direction.
  2. Next head = head ± 1 on the chosen axis.
  3. Wall check uses the pre-move head, so there is no modular wrap. Wall collision occurs if head_x = 0 moving left, head_x = `GRID_W`−1 moving right, head_y = 0 moving up, or head_y = `GRID_H`−1 moving down.
  4. Self check compares the next head against seg[1..len−2] when not growing, because the tail vacates. When growing it compares against seg[1..len−1].
  5. Any collision → DEAD. No segment, length or direction update occurs on that step.
  6. Otherwise seg[i] ← seg[i−1] for all i ≥ 1 and seg[0] ← next head.
  7. If growing and `len` < `MAX_LEN`: `len` ← `len`+1 and grow_pend cleared. If the new `len` = `MAX_LEN`, state ← WON.
- Growth:
  - `grow` sets grow_pend. Growth is applied on the next successful step.
  - `grow` and `step` in the same cycle: the growth applies to that step.
  - Multiple `grow` pulses between steps collapse to one growth.
  - `grow` while `len` = `MAX_LEN` is ignored.
- DEAD/WON: all state frozen. Only `rst` exits.
- `start` outside IDLE is ignored.

## Timing

- A step commits on the same `clk` edge that samples `step`=1. `head_x`, `head_y`, `len` and `state` are valid the following cycle.
- Query latency is 1 cycle. `hit_head`/`hit_body` at edge n+1 reflect `qx`/`qy` at edge n, against the segment state before that edge.
- The query runs MAX_LEN parallel comparators reduced by OR in a single cycle. There is no query pipeline beyond the output register.
- `hit_*` updates in every state, including IDLE, DEAD and WON, so the frozen snake stays drawable.
- Reset asserted mid-step takes priority: the step is discarded.
- Steps must be ≥ 2 cycles apart. Back-to-back steps are undefined.

## Test plan

- Reset, `start`, 3 steps with `dir_in`=00 (defaults) → head (19,12), `len`=3, state RUN. Query (18,12) → `hit_body`=1 one cycle later. Query (16,12) → 0.
- Heading right, step with `dir_in`=10 (reverse) → head x+1, direction stays right. Then step with `dir_in`=01 → head y−1.
- `grow` pulse, then 2 steps → `len`=4 after the first step and stays 4 after the second. Tail cell from before the first step is still `hit_body`.
- Drive the head to x=`GRID_W`−1, step right → state DEAD, head unchanged, further steps and `grow` have no effect. `rst` → IDLE, head (16,12), `len`=3.
- Self collision at `len`=5 (grow twice, then steps up, left, down) → DEAD on the down step. Also a tail-chase at `len`=4 without growth → no death.
- `MAX_LEN`=4 build: one growth step → `len`=4 and state WON. Later `grow` and `step` are ignored.
